apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin APB master controller.
- Shares one APB4 bus among NUM_REQ on-chip requesters.
- Accepts one request at a time, sequences the SETUP/ACCESS phases and returns the read data or error to the granted requester.
- Terminates stalled transfers with a PREADY timeout.
- Sits between the bridge-side request sources and the APB slave interface (PSEL/PENABLE/PREADY bus).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PDATA_SIZE, 32, APB address/data width (bits, multiple of 8).
- TIMEOUT, 16, consecutive ACCESS cycles with PREADY=0 before forced termination; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_write  in  NUM_REQ  per-requester 1=write.
- req_addr  in  NUM_REQ*PDATA_SIZE  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*PDATA_SIZE  packed write data.
- req_strb  in  NUM_REQ*PDATA_SIZE/8  packed byte strobes.
- req_prot  in  NUM_REQ*3  packed protection.
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: transfer complete.
- rsp_rdata  out  PDATA_SIZE  read data; valid with rsp_valid.
- rsp_slverr  out  1  error flag; valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PPROT  out  3  APB protection.
- PSTRB  out  PDATA_SIZE/8  APB byte strobes.
- PADDR, PWDATA  out  PDATA_SIZE  APB address and write data.
- PRDATA  in  PDATA_SIZE  APB read data.
- PREADY, PSLVERR  in  1  APB slave response.

Behaviour:
- Reset (PRESETn=0, async):
  - All outputs go to 0.
  - State goes to IDLE and the timeout counter clears.
  - The round-robin pointer is set so requester 0 has highest priority.
  - A transfer in flight is abandoned; no rsp_valid is issued for it.
- All outputs are registered; no combinational input-to-output paths.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid=1, grant requester g, the first set bit searched from (last_grant+1) mod NUM_REQ upward with wrap.
  - On the next edge:
    - Latch slice g of addr/wdata/strb/prot/write onto PADDR/PWDATA/PSTRB/PPROT/PWRITE.
    - PSEL=1, PENABLE=0, req_ack[g]=1 for that cycle, last_grant=g, go to SETUP.
- SETUP: next edge PENABLE=1, go to ACCESS. Unconditional, exactly one cycle.
- ACCESS, edge with PREADY=1:
  - rsp_valid[g]=1 for one cycle.
  - rsp_rdata=PRDATA for reads, 0 for writes.
  - rsp_slverr=PSLVERR.
  - PENABLE=0.
  - If any req_valid=1 at that edge (the completing requester's own valid included), perform the IDLE grant in the same edge: PSEL stays 1, go to SETUP (back-to-back, no idle cycle).
  - Otherwise PSEL=0 and go to IDLE.
- ACCESS, PREADY=0:
  - All APB outputs are held stable.
  - The counter increments.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT:
    - rsp_valid[g]=1, rsp_slverr=1, rsp_rdata=0.
    - PSEL=0, PENABLE=0, go to IDLE.
  - The counter clears on every entry to SETUP.
- Latency: request sampled at edge N gives PSEL at N, PENABLE at N+1, earliest rsp_valid at N+2 (zero-wait slave).
- Reads: PSTRB is driven 0 and PWDATA 0.
- Requester rules:
  - Hold req_valid and its fields stable until req_ack.
  - Dropping req_valid before ack withdraws the request with no side effects.
  - Each requester has at most one outstanding transfer; a req_valid re-asserted before its rsp_valid is ignored until completion.
- Arbitration:
  - Requests arriving during SETUP/ACCESS wait; none is starved.
  - With all NUM_REQ requesting continuously, grant order is 0,1,2,3,0...
- rsp_valid and req_ack to different requesters may pulse in the same cycle.
- PSLVERR is ignored when PREADY=0.

Test Plan:
- Single write, requester 1, addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, PREADY tied 1 -> PSEL at N, PENABLE at N+1, rsp_valid[1] at N+2, rsp_slverr=0, PWRITE=1, PADDR/PWDATA match.
- Read from requester 2 with PREADY low 3 cycles, PRDATA=0x1234_5678 -> APB outputs stable 3 ACCESS cycles, rsp_valid[2] with rsp_rdata=0x1234_5678, PSTRB=0.
- All 4 requesters valid continuously, zero-wait slave -> grants 0,1,2,3,0 back-to-back, PSEL never drops, each transfer exactly 2 cycles.
- PREADY held 0 with TIMEOUT=16 -> after 16 ACCESS cycles rsp_valid, rsp_slverr=1, rsp_rdata=0, PSEL=0; next request proceeds normally.
- PSLVERR=1 with PREADY=1 on write from requester 3 -> rsp_valid[3], rsp_slverr=1; PSLVERR=1 with PREADY=0 has no effect.
- PRESETn asserted during ACCESS -> all outputs 0 immediately (async), no rsp_valid; after release requester 0 wins a tie with requester 3.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB4 master shared by NUM_REQ on-chip requesters.
// One transfer is in flight at a time. The granted requester gets a one-cycle
// req_ack when its request is launched and a one-cycle rsp_valid when the slave
// completes it, or when the PREADY timeout terminates it. Every output is a flop.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int PDATA_SIZE = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]    req_addr,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]    req_wdata,
    input  logic [NUM_REQ*PDATA_SIZE/8-1:0]  req_strb,
    input  logic [NUM_REQ*3-1:0]             req_prot,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [PDATA_SIZE-1:0]            rsp_rdata,
    output logic                             rsp_slverr,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [2:0]                       PPROT,
    output logic [PDATA_SIZE/8-1:0]          PSTRB,
    output logic [PDATA_SIZE-1:0]            PADDR,
    output logic [PDATA_SIZE-1:0]            PWDATA,
    input  logic [PDATA_SIZE-1:0]            PRDATA,
    input  logic                             PREADY,
    input  logic                             PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    // The counter only has to hold 0..TIMEOUT-1; termination happens on the
    // waited cycle that would take it to TIMEOUT.
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [PDATA_SIZE-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [2:0]             pprot_q, pprot_d;
    logic [STRB_W-1:0]      pstrb_q, pstrb_d;
    logic [PDATA_SIZE-1:0]  paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0]  pwdata_q, pwdata_d;

    logic                   grant_found;
    logic [IDX_W-1:0]       grant_idx;
    logic                   do_grant;

    // Per-requester views of the packed request buses.
    logic [PDATA_SIZE-1:0]  addr_arr  [NUM_REQ];
    logic [PDATA_SIZE-1:0]  wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]      strb_arr  [NUM_REQ];
    logic [2:0]             prot_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*PDATA_SIZE +: PDATA_SIZE];
        assign wdata_arr[i] = req_wdata[i*PDATA_SIZE +: PDATA_SIZE];
        assign strb_arr[i]  = req_strb[i*STRB_W +: STRB_W];
        assign prot_arr[i]  = req_prot[i*3 +: 3];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[IDX_W'((int'(last_grant_q) + k) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_ack_d    = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_slverr_d = 1'b0;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pprot_d      = pprot_q;
        pstrb_d      = pstrb_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        do_grant     = 1'b0;

        unique case (state_q)
            IDLE: begin
                do_grant = grant_found;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d  = NUM_REQ'(1) << last_grant_q;
                    rsp_rdata_d  = pwrite_q ? '0 : PRDATA;
                    rsp_slverr_d = PSLVERR;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = IDLE;
                    // Back-to-back: a pending request is launched on the completing edge.
                    do_grant     = grant_found;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rsp_valid_d  = NUM_REQ'(1) << last_grant_q;
                    rsp_slverr_d = 1'b1;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            state_d      = SETUP;
            last_grant_d = grant_idx;
            cnt_d        = '0;
            req_ack_d    = NUM_REQ'(1) << grant_idx;
            psel_d       = 1'b1;
            penable_d    = 1'b0;
            pwrite_d     = req_write[grant_idx];
            paddr_d      = addr_arr[grant_idx];
            pprot_d      = prot_arr[grant_idx];
            // Reads drive zero write data and strobes.
            pwdata_d     = req_write[grant_idx] ? wdata_arr[grant_idx] : '0;
            pstrb_d      = req_write[grant_idx] ? strb_arr[grant_idx] : '0;
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            // Pointing at the last requester gives requester 0 top priority.
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            req_ack_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pprot_q      <= '0;
            pstrb_q      <= '0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_ack_q    <= req_ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pprot_q      <= pprot_d;
            pstrb_q      <= pstrb_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PPROT      = pprot_q;
    assign PSTRB      = pstrb_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [N-1:0]    req_valid, req_write;
    logic [N*DW-1:0] req_addr, req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N*3-1:0]  req_prot;
    logic [N-1:0]    req_ack, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;
    logic            PSEL, PENABLE, PWRITE;
    logic [2:0]      PPROT;
    logic [SW-1:0]   PSTRB;
    logic [DW-1:0]   PADDR, PWDATA, PRDATA;
    logic            PREADY, PSLVERR;

    apb_req_arbiter #(.NUM_REQ(N), .PDATA_SIZE(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT),
        .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (one transfer record + rr pointer) ----
    typedef struct {
        bit            wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
    } txn_t;

    bit            m_busy, m_access;
    int            m_owner, m_ptr, m_waits;
    txn_t          m_txn;
    logic [N-1:0]  exp_ack, exp_rsp;
    logic [DW-1:0] exp_rdata;
    logic          exp_slverr;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_access = 0; m_ptr = N - 1; m_waits = 0; m_owner = 0;
        exp_ack = '0; exp_rsp = '0; exp_rdata = '0; exp_slverr = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic m_update();
        bit was_busy, done_ok;
        int g;
        exp_ack = '0; exp_rsp = '0; exp_rdata = '0; exp_slverr = 1'b0;
        if (!PRESETn) begin
            m_reset();
            return;
        end
        was_busy = m_busy;
        done_ok  = 0;
        if (m_busy && !m_access) begin
            m_access = 1;
        end else if (m_busy) begin
            if (PREADY) begin
                exp_rsp    = N'(1) << m_owner;
                exp_rdata  = m_txn.wr ? '0 : PRDATA;
                exp_slverr = PSLVERR;
                m_busy     = 0;
                done_ok    = 1;
            end else begin
                m_waits++;
                if (m_waits == TO) begin
                    exp_rsp    = N'(1) << m_owner;
                    exp_slverr = 1'b1;
                    m_busy     = 0;
                end
            end
        end
        if ((!was_busy || done_ok) && req_valid != '0) begin
            g = rr_pick(req_valid, m_ptr);
            m_ptr = g; m_owner = g;
            m_busy = 1; m_access = 0; m_waits = 0;
            m_txn.wr    = req_write[g];
            m_txn.addr  = req_addr[g*DW +: DW];
            m_txn.prot  = req_prot[g*3 +: 3];
            m_txn.wdata = req_write[g] ? req_wdata[g*DW +: DW] : '0;
            m_txn.strb  = req_write[g] ? req_strb[g*SW +: SW] : '0;
            exp_ack = N'(1) << g;
        end
    endtask

    // ---------------- stimulus agents ----------------
    bit            cont_mode = 0, rand_mode = 0, slv_rand = 0;
    int            slv_wait = 0, acc_cnt = 0;
    logic          slv_err = 0, slv_err_wait = 0;
    logic [DW-1:0] slv_rdata = '0;

    int            cyc = 0, rsp_seen = 0, pen_cnt = 0, rsp_cyc = 0;
    logic [DW-1:0] last_rdata;
    logic          last_slverr;
    int            ack_log[$];
    int            ack_cyc[$];

    task automatic set_req(input int i, input bit wr, input logic [DW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*DW +: DW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW]  = s;
        req_prot[i*3 +: 3]    = p;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom));
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ack[i]) begin
                req_valid[i] = 1'b0;
                if (cont_mode) rand_req(i);
            end else if (rand_mode) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) rand_req(i);
                else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_slave();
        if (slv_rand) begin
            PREADY  = ($urandom_range(0, 2) != 0);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end else begin
            PRDATA = slv_rdata;
            if (PENABLE) begin
                if (acc_cnt >= slv_wait) begin PREADY = 1'b1; PSLVERR = slv_err; end
                else begin PREADY = 1'b0; PSLVERR = slv_err_wait; end
                acc_cnt++;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b0; acc_cnt = 0;
            end
        end
    endtask

    task automatic compare();
        check("psel", 64'(PSEL), 64'(m_busy));
        check("penable", 64'(PENABLE), 64'(m_busy && m_access));
        check("req_ack", 64'(req_ack), 64'(exp_ack));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (exp_rsp != '0) begin
            check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            check("rsp_slverr", 64'(rsp_slverr), 64'(exp_slverr));
        end
        if (m_busy) begin
            check("pwrite", 64'(PWRITE), 64'(m_txn.wr));
            check("paddr", 64'(PADDR), 64'(m_txn.addr));
            check("pwdata", 64'(PWDATA), 64'(m_txn.wdata));
            check("pstrb", 64'(PSTRB), 64'(m_txn.strb));
            check("pprot", 64'(PPROT), 64'(m_txn.prot));
        end
        for (int i = 0; i < N; i++)
            if (req_ack[i]) begin ack_log.push_back(i); ack_cyc.push_back(cyc); end
        if (PENABLE) pen_cnt++;
        if (rsp_valid != '0) begin
            rsp_seen++; rsp_cyc = cyc; last_rdata = rsp_rdata; last_slverr = rsp_slverr;
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        cyc++;
        m_update();
        @(negedge PCLK);
        compare();
        drive_reqs();
        drive_slave();
    endtask

    task automatic run_until_rsp(input string tag, input int budget);
        int start;
        bit got;
        start = rsp_seen;
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            step();
            if (rsp_seen != start) got = 1;
        end
        if (!got) check({tag, "_rsp_bound"}, 64'(got), 64'(1));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit idle;
        idle = 0;
        for (int k = 0; k < budget && !idle; k++) begin
            step();
            if (!m_busy && req_valid == '0) idle = 1;
        end
        if (!idle) check({tag, "_idle_bound"}, 64'(idle), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pen_seen;
        int ack0;
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        m_reset();
        repeat (2) @(negedge PCLK);

        // Reset state.
        check("rst_psel", 64'(PSEL), 64'(0));
        check("rst_penable", 64'(PENABLE), 64'(0));
        check("rst_req_ack", 64'(req_ack), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_paddr", 64'(PADDR), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        PRESETn = 1'b1;

        // Single zero-wait write from requester 1.
        slv_wait = 0;
        ack_log.delete(); ack_cyc.delete();
        set_req(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000);
        run_until_rsp("t1", 10);
        check("t1_ack_id", 64'(ack_log.size() > 0 ? ack_log[0] : -1), 64'(1));
        check("t1_latency", 64'(ack_cyc.size() > 0 ? rsp_cyc - ack_cyc[0] : -1), 64'(2));
        check("t1_slverr", 64'(last_slverr), 64'(0));
        wait_idle("t1", 10);

        // Read from requester 2 with three wait states.
        slv_wait = 3; slv_rdata = 32'h1234_5678;
        pen_cnt = 0;
        set_req(2, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 3'b010);
        run_until_rsp("t2", 20);
        check("t2_rdata", 64'(last_rdata), 64'h1234_5678);
        check("t2_access_cycles", 64'(pen_cnt), 64'(4));
        wait_idle("t2", 10);

        // All requesters continuously valid: strict rotation, 2 cycles each.
        // Last grant was requester 2, so rotation starts at 3.
        slv_wait = 0; cont_mode = 1;
        ack_log.delete(); ack_cyc.delete();
        for (int i = 0; i < N; i++) rand_req(i);
        repeat (20) step();
        cont_mode = 0;
        req_valid = '0;
        wait_idle("t3", 10);
        check("t3_grant_count", 64'(ack_log.size() >= 8), 64'(1));
        for (int j = 0; j < 8 && j < ack_log.size(); j++) begin
            check("t3_grant_order", 64'(ack_log[j]), 64'((3 + j) % N));
            if (j > 0) check("t3_grant_spacing", 64'(ack_cyc[j] - ack_cyc[j-1]), 64'(2));
        end

        // PREADY stuck low: timeout after TO access cycles, then normal transfer.
        slv_wait = 1000; slv_err_wait = 1'b0;
        pen_cnt = 0;
        set_req(0, 1'b0, 32'h0000_0200, '0, '0, 3'b001);
        run_until_rsp("t4", TO + 10);
        check("t4_access_cycles", 64'(pen_cnt), 64'(TO));
        check("t4_slverr", 64'(last_slverr), 64'(1));
        check("t4_rdata", 64'(last_rdata), 64'(0));
        check("t4_psel_low", 64'(PSEL), 64'(0));
        slv_wait = 0;
        set_req(1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'h3, 3'b100);
        run_until_rsp("t4b", 10);
        check("t4b_slverr", 64'(last_slverr), 64'(0));
        wait_idle("t4", 10);

        // PSLVERR only counts on the completing cycle.
        slv_wait = 2; slv_err = 1'b1; slv_err_wait = 1'b0;
        set_req(3, 1'b1, 32'h0000_0400, 32'h0BAD_0BAD, 4'hF, 3'b000);
        run_until_rsp("t5", 20);
        check("t5_slverr_ready", 64'(last_slverr), 64'(1));
        slv_err = 1'b0; slv_err_wait = 1'b1;
        set_req(3, 1'b1, 32'h0000_0404, 32'h600D_600D, 4'hF, 3'b000);
        run_until_rsp("t5b", 20);
        check("t5_slverr_waiting", 64'(last_slverr), 64'(0));
        slv_err_wait = 1'b0;
        wait_idle("t5", 10);

        // Random traffic against the model.
        rand_mode = 1; slv_rand = 1;
        repeat (3000) step();
        rand_mode = 0; slv_rand = 0; slv_wait = 0;
        req_valid = '0;
        wait_idle("rand", 40);

        // Async reset in ACCESS, then requester 0 beats requester 3.
        slv_wait = 10;
        set_req(1, 1'b1, 32'h0000_0500, 32'h1111_2222, 4'hF, 3'b000);
        pen_seen = 0;
        for (int k = 0; k < 10 && !pen_seen; k++) begin
            step();
            if (PENABLE) pen_seen = 1;
        end
        check("t6_reached_access", 64'(pen_seen), 64'(1));
        #2 PRESETn = 1'b0;
        #1;
        check("t6_rst_psel", 64'(PSEL), 64'(0));
        check("t6_rst_penable", 64'(PENABLE), 64'(0));
        check("t6_rst_pwrite", 64'(PWRITE), 64'(0));
        check("t6_rst_paddr", 64'(PADDR), 64'(0));
        check("t6_rst_pwdata", 64'(PWDATA), 64'(0));
        check("t6_rst_pstrb", 64'(PSTRB), 64'(0));
        check("t6_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        m_reset();
        repeat (2) step();
        PRESETn = 1'b1;
        slv_wait = 0;
        ack_log.delete(); ack_cyc.delete();
        set_req(3, 1'b0, 32'h0000_0600, '0, '0, 3'b000);
        set_req(0, 1'b1, 32'h0000_0700, 32'h7777_8888, 4'hC, 3'b011);
        run_until_rsp("t6", 10);
        ack0 = (ack_log.size() > 0) ? ack_log[0] : -1;
        check("t6_tie_winner", 64'(ack0), 64'(0));
        wait_idle("t6", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
